ord_req_tagger: RTL and testbench

Issue-side companion of the reorder buffer. It accepts untagged burst requests, assigns each a transaction ID from a fixed pool 0..ORD_DEPTH-1 by round-robin, and forwards the tagged request to the fabric. It pushes the matching {id, len} entry into the reorder buffer's order queue. It also watches in-order data leaving the reorder buffer, retires each burst on its last beat, and frees that burst's ID slot, which bounds outstanding traffic per ID and in total.

---
 rtl/ord_req_tagger_if.sv | 46 ++++
 rtl/ord_req_tagger.sv | 166 ++++++++++++++++
 tb/tb_ord_req_tagger.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ord_req_tagger_if.sv
// Request, tagged-request, order-entry and retire-monitor bundle for ord_req_tagger.
// master = tagger side, slave = surrounding fabric / reorder buffer side.
interface ord_req_tagger_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LEN_W  = 16,
   parameter int unsigned ID_W   = 2
);
   logic [ADDR_W-1:0] req_addr;
   logic [LEN_W-1:0]  req_len;
   logic              req_vld;
   logic              req_rdy;
   logic [ID_W-1:0]   mst_id;
   logic [ADDR_W-1:0] mst_addr;
   logic [LEN_W-1:0]  mst_len;
   logic              mst_vld;
   logic              mst_rdy;
   logic [ID_W-1:0]   ord_id;
   logic [LEN_W-1:0]  ord_len;
   logic              ord_vld;
   logic              ord_rdy;
   logic              fwd_vld;
   logic              fwd_rdy;
   logic              err;

   modport master (
      input  req_addr, req_len, req_vld,
      output req_rdy,
      output mst_id, mst_addr, mst_len, mst_vld,
      input  mst_rdy,
      output ord_id, ord_len, ord_vld,
      input  ord_rdy,
      input  fwd_vld, fwd_rdy,
      output err
   );

   modport slave (
      output req_addr, req_len, req_vld,
      input  req_rdy,
      input  mst_id, mst_addr, mst_len, mst_vld,
      output mst_rdy,
      input  ord_id, ord_len, ord_vld,
      output ord_rdy,
      output fwd_vld, fwd_rdy,
      input  err
   );
endinterface

// File: rtl/ord_req_tagger.sv
// Round-robin ID tagger feeding the fabric and the reorder buffer order queue; retires bursts
// from the in-order output stream. Optional ORD_REQ_TAGGER_ERR_EN enables the sticky err flag.
module ord_req_tagger #(
   parameter int unsigned ORD_DEPTH = 4,
   parameter int unsigned ID_W      = $clog2(ORD_DEPTH),
   parameter int unsigned MAX_OUTST = 4,
   parameter int unsigned BUF_DEPTH = 16,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned LEN_W     = 16
) (
   input logic              clk,
   input logic              rst,
   ord_req_tagger_if.master bus
);
   localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
   localparam int unsigned TRK_W = $clog2(BUF_DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
   localparam logic [TRK_W-1:0] TRK_MAX = TRK_W'(BUF_DEPTH);
   localparam logic [ID_W-1:0]  ID_LAST = ID_W'(ORD_DEPTH - 1);

   typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

   state_t            state, state_nxt;
   logic              mst_done, ord_done, mst_done_nxt, ord_done_nxt;
   logic [ID_W-1:0]   out_id;
   logic [ADDR_W-1:0] out_addr;
   logic [LEN_W-1:0]  out_len;
   logic [ID_W-1:0]   rr_ptr;
   logic [CNT_W-1:0]  outst_cnt [ORD_DEPTH];
   logic [TRK_W-1:0]  trk_cnt;
   logic [LEN_W-1:0]  beat_cnt;
   logic [ID_W-1:0]   rl_id  [BUF_DEPTH];
   logic [LEN_W-1:0]  rl_len [BUF_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [ID_W-1:0]   sel_id, head_id;
   logic [LEN_W-1:0]  head_len;
   logic              id_avail, req_rdy, accept, mst_vld, ord_vld;
   logic              fwd_hsk, rl_empty, retire;

   always_comb begin
      int unsigned     idx;
      logic [ID_W-1:0] cand;
      idx      = 0;
      cand     = '0;
      sel_id   = '0;
      id_avail = 1'b0;
      for (int unsigned i = 0; i < ORD_DEPTH; i++) begin
         idx = 32'(rr_ptr) + i;
         if (idx >= ORD_DEPTH) idx = idx - ORD_DEPTH;
         cand = ID_W'(idx);
         if (!id_avail && (outst_cnt[cand] < CNT_MAX)) begin
            id_avail = 1'b1;
            sel_id   = cand;
         end
      end
   end

   assign rl_empty = (trk_cnt == '0);
   assign head_id  = rl_id[rd_ptr];
   assign head_len = rl_len[rd_ptr];
   assign fwd_hsk  = bus.fwd_vld & bus.fwd_rdy;
   assign retire   = fwd_hsk & ~rl_empty & (beat_cnt == head_len);
   assign req_rdy  = (state == IDLE) & id_avail & (trk_cnt < TRK_MAX) & ~rst;
   assign accept   = bus.req_vld & req_rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         mst_done <= 1'b0;
         ord_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         mst_done <= mst_done_nxt;
         ord_done <= ord_done_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      mst_done_nxt = mst_done;
      ord_done_nxt = ord_done;
      mst_vld      = 1'b0;
      ord_vld      = 1'b0;
      case (state)
         IDLE: if (accept) state_nxt = ISSUE;
         ISSUE: begin
            mst_vld = ~mst_done;
            ord_vld = ~ord_done;
            // Both handshakes are independent; leave as soon as the later one completes.
            if ((mst_done | (mst_vld & bus.mst_rdy)) & (ord_done | (ord_vld & bus.ord_rdy))) begin
               state_nxt    = IDLE;
               mst_done_nxt = 1'b0;
               ord_done_nxt = 1'b0;
            end else begin
               mst_done_nxt = mst_done | (mst_vld & bus.mst_rdy);
               ord_done_nxt = ord_done | (ord_vld & bus.ord_rdy);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_id   <= '0;
         out_addr <= '0;
         out_len  <= '0;
         rr_ptr   <= '0;
         trk_cnt  <= '0;
         beat_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         if (accept) begin
            out_id   <= sel_id;
            out_addr <= bus.req_addr;
            out_len  <= bus.req_len;
            rr_ptr   <= (sel_id == ID_LAST) ? '0 : sel_id + ID_W'(1);
            wr_ptr   <= wr_ptr + PTR_W'(1);
         end
         if (retire) rd_ptr <= rd_ptr + PTR_W'(1);
         if (accept && !retire)      trk_cnt <= trk_cnt + TRK_W'(1);
         else if (retire && !accept) trk_cnt <= trk_cnt - TRK_W'(1);
         if (fwd_hsk && !rl_empty) beat_cnt <= retire ? '0 : beat_cnt + LEN_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         rl_id[wr_ptr]  <= sel_id;
         rl_len[wr_ptr] <= bus.req_len;
      end
   end

   for (genvar g = 0; g < ORD_DEPTH; g++) begin : g_cnt
      logic inc, dec;
      assign inc = accept & (sel_id == ID_W'(g));
      assign dec = retire & (head_id == ID_W'(g));
      always_ff @(posedge clk) begin
         if (rst)              outst_cnt[g] <= '0;
         else if (inc && !dec) outst_cnt[g] <= outst_cnt[g] + CNT_W'(1);
         else if (dec && !inc) outst_cnt[g] <= outst_cnt[g] - CNT_W'(1);
      end
   end

`ifdef ORD_REQ_TAGGER_ERR_EN
   logic err_q;
   always_ff @(posedge clk) begin
      if (rst)                     err_q <= 1'b0;
      else if (fwd_hsk && rl_empty) err_q <= 1'b1;
   end
   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.req_rdy  = req_rdy;
   assign bus.mst_vld  = mst_vld;
   assign bus.mst_id   = out_id;
   assign bus.mst_addr = out_addr;
   assign bus.mst_len  = out_len;
   assign bus.ord_vld  = ord_vld;
   assign bus.ord_id   = out_id;
   assign bus.ord_len  = out_len;
endmodule

// File: tb/tb_ord_req_tagger.sv
// Bench for ord_req_tagger: directed scenarios on a default and a MAX_OUTST=1 instance, plus a
// randomized run against a queue-based reference model.
module tb_ord_req_tagger;
   localparam int unsigned ND = 4, IW = 2, AW = 32, LW = 16, MO = 4, BD = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ord_req_tagger_if #(.ADDR_W(AW), .LEN_W(LW), .ID_W(IW)) bus ();
   ord_req_tagger_if #(.ADDR_W(AW), .LEN_W(LW), .ID_W(IW)) bus1 ();

   ord_req_tagger #(.ORD_DEPTH(ND), .ID_W(IW), .MAX_OUTST(MO), .BUF_DEPTH(BD),
                    .ADDR_W(AW), .LEN_W(LW))
      u_dut (.clk(clk), .rst(rst), .bus(bus.master));

   ord_req_tagger #(.ORD_DEPTH(ND), .ID_W(IW), .MAX_OUTST(1), .BUF_DEPTH(BD),
                    .ADDR_W(AW), .LEN_W(LW))
      u_dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

   int n_chk = 0;
   int n_fail = 0;

   typedef struct { int id; int len; } ent_t;
   ent_t            q[$];
   int              m_cnt [ND];
   int              m_rr, m_beat;
   bit              m_busy, m_mp, m_op;
   logic [IW-1:0]   m_id;
   logic [AW-1:0]   m_addr;
   logic [LW-1:0]   m_len;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req_addr = '0; bus.req_len = '0; bus.req_vld = 1'b0;
      bus.mst_rdy = 1'b0; bus.ord_rdy = 1'b0; bus.fwd_vld = 1'b0; bus.fwd_rdy = 1'b0;
      bus1.req_addr = '0; bus1.req_len = '0; bus1.req_vld = 1'b0;
      bus1.mst_rdy = 1'b0; bus1.ord_rdy = 1'b0; bus1.fwd_vld = 1'b0; bus1.fwd_rdy = 1'b0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   // Drives one request and waits for it to be accepted and fully handed off (both rdys assumed 1).
   task automatic issue_req(input bit sel1, input logic [LW-1:0] l,
                            output logic [IW-1:0] id, output bit ok);
      int w;
      logic [AW-1:0] a;
      w = 0;
      a = $urandom;
      if (sel1) begin bus1.req_addr = a; bus1.req_len = l; bus1.req_vld = 1'b1; end
      else begin bus.req_addr = a; bus.req_len = l; bus.req_vld = 1'b1; end
      #1;
      while (((sel1 ? bus1.req_rdy : bus.req_rdy) !== 1'b1) && w < 40) begin
         tick();
         w++;
      end
      ok = ((sel1 ? bus1.req_rdy : bus.req_rdy) === 1'b1);
      if (ok) tick();
      bus.req_vld = 1'b0;
      bus1.req_vld = 1'b0;
      id = sel1 ? bus1.mst_id : bus.mst_id;
      if (ok) tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      n_chk++;
      if ({bus.req_rdy, bus.mst_vld, bus.ord_vld, bus.err, bus1.req_rdy} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got rdy/mv/ov/err/rdy1=%b want 00000",
                  {bus.req_rdy, bus.mst_vld, bus.ord_vld, bus.err, bus1.req_rdy});
      end
      n_chk++;
      if ({bus.mst_id, bus.mst_addr, bus.mst_len, bus.ord_id, bus.ord_len} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got id=%0d addr=%h len=%0d oid=%0d olen=%0d want all 0",
                  bus.mst_id, bus.mst_addr, bus.mst_len, bus.ord_id, bus.ord_len);
      end
      rst = 1'b0;
      #1;
      n_chk++;
      if (bus.req_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_rdy: got %b want 1", bus.req_rdy);
      end
   endtask

   task automatic test_round_robin();
      int cyc, last, w;
      logic [AW-1:0] a;
      logic [LW-1:0] l;
      logic [IW-1:0] e;
      apply_reset();
      bus.mst_rdy = 1'b1;
      bus.ord_rdy = 1'b1;
      cyc = 0;
      last = 0;
      for (int k = 0; k < 5; k++) begin
         a = $urandom;
         l = LW'($urandom_range(0, 255));
         e = IW'(k % ND);
         bus.req_addr = a; bus.req_len = l; bus.req_vld = 1'b1;
         #1;
         w = 0;
         while (bus.req_rdy !== 1'b1 && w < 20) begin tick(); w++; cyc++; end
         if (k > 0) begin
            n_chk++;
            if (cyc - last != 2) begin
               n_fail++;
               $display("FAIL rr_spacing[%0d]: got %0d cycles want 2", k, cyc - last);
            end
         end
         last = cyc;
         tick();
         cyc++;
         bus.req_vld = 1'b0;
         #1;
         n_chk++;
         if ({bus.mst_vld, bus.ord_vld, bus.mst_id, bus.ord_id} !== {2'b11, e, e}) begin
            n_fail++;
            $display("FAIL rr_id[%0d]: got mv=%b ov=%b id=%0d oid=%0d want 1 1 %0d %0d",
                     k, bus.mst_vld, bus.ord_vld, bus.mst_id, bus.ord_id, e, e);
         end
         n_chk++;
         if ({bus.mst_addr, bus.mst_len, bus.ord_len} !== {a, l, l}) begin
            n_fail++;
            $display("FAIL rr_payload[%0d]: got addr=%h len=%0d olen=%0d want %h %0d",
                     k, bus.mst_addr, bus.mst_len, bus.ord_len, a, l);
         end
      end
      tick();
   endtask

   task automatic test_per_id_limit();
      logic [IW-1:0] id;
      bit ok;
      logic [AW-1:0] a;
      apply_reset();
      bus1.mst_rdy = 1'b1;
      bus1.ord_rdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         issue_req(1'b1, '0, id, ok);
         n_chk++;
         if ({ok, id} !== {1'b1, IW'(k)}) begin
            n_fail++;
            $display("FAIL limit_fill[%0d]: got ok=%b id=%0d want 1 %0d", k, ok, id, k);
         end
      end
      a = $urandom;
      bus1.req_addr = a; bus1.req_len = '0; bus1.req_vld = 1'b1;
      tick();
      tick();
      n_chk++;
      if ({bus1.req_rdy, bus1.mst_vld} !== 2'b00) begin
         n_fail++;
         $display("FAIL limit_stall: got rdy=%b mv=%b want 0 0", bus1.req_rdy, bus1.mst_vld);
      end
      bus1.fwd_vld = 1'b1; bus1.fwd_rdy = 1'b1;
      #1;
      n_chk++;
      if (bus1.req_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL limit_retire_same_cycle: got rdy=%b want 0", bus1.req_rdy);
      end
      tick();
      bus1.fwd_vld = 1'b0; bus1.fwd_rdy = 1'b0;
      #1;
      n_chk++;
      if (bus1.req_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL limit_freed: got rdy=%b want 1", bus1.req_rdy);
      end
      tick();
      bus1.req_vld = 1'b0;
      #1;
      n_chk++;
      if ({bus1.mst_vld, bus1.mst_id, bus1.mst_addr} !== {1'b1, IW'(0), a}) begin
         n_fail++;
         $display("FAIL limit_reissue: got mv=%b id=%0d addr=%h want 1 0 %h",
                  bus1.mst_vld, bus1.mst_id, bus1.mst_addr, a);
      end
      tick();
   endtask

   task automatic test_split_handshake();
      logic [AW-1:0] a;
      logic [LW-1:0] l;
      apply_reset();
      a = $urandom;
      l = LW'($urandom_range(0, 65535));
      bus.req_addr = a; bus.req_len = l; bus.req_vld = 1'b1;
      bus.mst_rdy = 1'b0; bus.ord_rdy = 1'b1;
      tick();
      bus.req_vld = 1'b0;
      #1;
      n_chk++;
      if ({bus.mst_vld, bus.ord_vld, bus.mst_id, bus.mst_addr} !== {2'b11, IW'(0), a}) begin
         n_fail++;
         $display("FAIL split_first: got mv=%b ov=%b id=%0d addr=%h want 1 1 0 %h",
                  bus.mst_vld, bus.ord_vld, bus.mst_id, bus.mst_addr, a);
      end
      for (int k = 0; k < 2; k++) begin
         tick();
         n_chk++;
         if ({bus.mst_vld, bus.ord_vld, bus.req_rdy, bus.mst_id, bus.mst_addr, bus.mst_len}
             !== {3'b100, IW'(0), a, l}) begin
            n_fail++;
            $display("FAIL split_hold[%0d]: got mv=%b ov=%b rdy=%b id=%0d addr=%h len=%0d",
                     k, bus.mst_vld, bus.ord_vld, bus.req_rdy, bus.mst_id, bus.mst_addr,
                     bus.mst_len);
         end
      end
      tick();
      bus.mst_rdy = 1'b1;
      #1;
      n_chk++;
      if ({bus.mst_vld, bus.ord_vld, bus.req_rdy, bus.mst_addr} !== {3'b100, a}) begin
         n_fail++;
         $display("FAIL split_mst_cycle: got mv=%b ov=%b rdy=%b addr=%h want 1 0 0 %h",
                  bus.mst_vld, bus.ord_vld, bus.req_rdy, bus.mst_addr, a);
      end
      tick();
      n_chk++;
      if ({bus.mst_vld, bus.ord_vld, bus.req_rdy} !== 3'b001) begin
         n_fail++;
         $display("FAIL split_done: got mv=%b ov=%b rdy=%b want 0 0 1",
                  bus.mst_vld, bus.ord_vld, bus.req_rdy);
      end
   endtask

   task automatic test_multibeat_retire();
      logic [IW-1:0] id;
      logic [4*IW-1:0] ids;
      bit ok;
      // MAX_OUTST=1 instance: only the 4th beat of the len=3 burst frees ID0.
      apply_reset();
      bus1.mst_rdy = 1'b1; bus1.ord_rdy = 1'b1;
      ids = '0;
      for (int k = 0; k < 4; k++) begin
         issue_req(1'b1, (k == 0) ? LW'(3) : LW'(0), id, ok);
         ids = {id, ids[4*IW-1:IW]};
         if (!ok) ids = '1;
      end
      n_chk++;
      if (ids !== 8'b11_10_01_00) begin
         n_fail++;
         $display("FAIL mb_fill_ids: got %b want 11100100", ids);
      end
      for (int b = 0; b < 4; b++) begin
         bus1.fwd_vld = 1'b1; bus1.fwd_rdy = 1'b1;
         tick();
         bus1.fwd_vld = 1'b0; bus1.fwd_rdy = 1'b0;
         #1;
         n_chk++;
         if (bus1.req_rdy !== ((b == 3) ? 1'b1 : 1'b0)) begin
            n_fail++;
            $display("FAIL mb_beat[%0d]: got rdy=%b want %b", b, bus1.req_rdy, (b == 3));
         end
      end
      // Default instance: accept to ID0 on the retiring beat of ID0, then refill to the total limit.
      apply_reset();
      bus.mst_rdy = 1'b1; bus.ord_rdy = 1'b1;
      for (int k = 0; k < 4; k++) issue_req(1'b0, (k == 0) ? LW'(3) : LW'(0), id, ok);
      bus.fwd_vld = 1'b1; bus.fwd_rdy = 1'b1;
      tick();
      tick();
      tick();
      bus.req_addr = $urandom; bus.req_len = '0; bus.req_vld = 1'b1;
      #1;
      n_chk++;
      if (bus.req_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL mb_sim_rdy: got %b want 1", bus.req_rdy);
      end
      tick();
      bus.fwd_vld = 1'b0; bus.fwd_rdy = 1'b0; bus.req_vld = 1'b0;
      #1;
      n_chk++;
      if ({bus.mst_vld, bus.mst_id} !== {1'b1, IW'(0)}) begin
         n_fail++;
         $display("FAIL mb_sim_id: got mv=%b id=%0d want 1 0", bus.mst_vld, bus.mst_id);
      end
      tick();
      for (int k = 0; k < 12; k++) begin
         issue_req(1'b0, '0, id, ok);
         n_chk++;
         if ({ok, id} !== {1'b1, IW'((k + 1) % ND)}) begin
            n_fail++;
            $display("FAIL total_fill[%0d]: got ok=%b id=%0d want 1 %0d", k, ok, id, (k + 1) % ND);
         end
      end
      bus.req_addr = $urandom; bus.req_vld = 1'b1;
      tick();
      n_chk++;
      if (bus.req_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL total_full: got rdy=%b want 0", bus.req_rdy);
      end
      bus.fwd_vld = 1'b1; bus.fwd_rdy = 1'b1;
      tick();
      bus.fwd_vld = 1'b0; bus.fwd_rdy = 1'b0;
      #1;
      n_chk++;
      if (bus.req_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL total_freed: got rdy=%b want 1", bus.req_rdy);
      end
      tick();
      bus.req_vld = 1'b0;
      #1;
      n_chk++;
      if ({bus.mst_vld, bus.mst_id} !== {1'b1, IW'(1)}) begin
         n_fail++;
         $display("FAIL total_reissue: got mv=%b id=%0d want 1 1", bus.mst_vld, bus.mst_id);
      end
      tick();
   endtask

   task automatic test_error_and_reset();
      logic exp_err;
      logic [IW-1:0] id;
      bit ok;
`ifdef ORD_REQ_TAGGER_ERR_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      apply_reset();
      bus.fwd_vld = 1'b1; bus.fwd_rdy = 1'b1;
      tick();
      bus.fwd_vld = 1'b0; bus.fwd_rdy = 1'b0;
      #1;
      n_chk++;
      if (bus.err !== exp_err) begin
         n_fail++;
         $display("FAIL err_set: got %b want %b", bus.err, exp_err);
      end
      tick();
      n_chk++;
      if (bus.err !== exp_err) begin
         n_fail++;
         $display("FAIL err_sticky: got %b want %b", bus.err, exp_err);
      end
      bus.mst_rdy = 1'b1; bus.ord_rdy = 1'b1;
      issue_req(1'b0, '0, id, ok);
      n_chk++;
      if ({ok, id} !== {1'b1, IW'(0)}) begin
         n_fail++;
         $display("FAIL err_no_side_effect: got ok=%b id=%0d want 1 0", ok, id);
      end
      // Park a request in ISSUE, then reset mid-burst.
      bus.mst_rdy = 1'b0; bus.ord_rdy = 1'b0;
      bus.req_len = LW'(5); bus.req_vld = 1'b1;
      tick();
      bus.req_vld = 1'b0;
      rst = 1'b1;
      tick();
      n_chk++;
      if ({bus.req_rdy, bus.mst_vld, bus.ord_vld, bus.err, bus.mst_id, bus.mst_len} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_hold: got rdy=%b mv=%b ov=%b err=%b id=%0d len=%0d want all 0",
                  bus.req_rdy, bus.mst_vld, bus.ord_vld, bus.err, bus.mst_id, bus.mst_len);
      end
      rst = 1'b0;
      #1;
      n_chk++;
      if ({bus.req_rdy, bus.mst_vld, bus.ord_vld, bus.err} !== 4'b1000) begin
         n_fail++;
         $display("FAIL rst_mid_release: got rdy=%b mv=%b ov=%b err=%b want 1 0 0 0",
                  bus.req_rdy, bus.mst_vld, bus.ord_vld, bus.err);
      end
      bus.fwd_vld = 1'b1; bus.fwd_rdy = 1'b1;
      tick();
      bus.fwd_vld = 1'b0; bus.fwd_rdy = 1'b0;
      #1;
      n_chk++;
      if (bus.err !== exp_err) begin
         n_fail++;
         $display("FAIL rst_list_dropped: got err=%b want %b", bus.err, exp_err);
      end
   endtask

   task automatic test_random();
      int exp_sel, c;
      bit exp_rdy, was_busy, fwd_hsk;
      apply_reset();
      q.delete();
      for (int i = 0; i < ND; i++) m_cnt[i] = 0;
      m_rr = 0; m_beat = 0; m_busy = 0; m_mp = 0; m_op = 0;
      m_id = '0; m_addr = '0; m_len = '0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         bus.req_vld  = ($urandom_range(0, 99) < 60);
         bus.req_addr = $urandom;
         bus.req_len  = LW'($urandom_range(0, 3));
         bus.mst_rdy  = ($urandom_range(0, 99) < 60);
         bus.ord_rdy  = ($urandom_range(0, 99) < 60);
         bus.fwd_vld  = ($urandom_range(0, 99) < 60);
         bus.fwd_rdy  = ($urandom_range(0, 99) < 60) && (q.size() != 0);
         #1;
         exp_sel = -1;
         for (int i = 0; i < ND; i++) begin
            c = (m_rr + i) % ND;
            if (exp_sel < 0 && m_cnt[c] < MO) exp_sel = c;
         end
         exp_rdy = !m_busy && (exp_sel >= 0) && (q.size() < BD);
         n_chk++;
         if ({bus.req_rdy, bus.mst_vld, bus.ord_vld, bus.err}
             !== {exp_rdy, m_busy && m_mp, m_busy && m_op, 1'b0}) begin
            n_fail++;
            $display("FAIL rand_ctrl@%0d: got rdy/mv/ov/err=%b want %b", cyc,
                     {bus.req_rdy, bus.mst_vld, bus.ord_vld, bus.err},
                     {exp_rdy, m_busy && m_mp, m_busy && m_op, 1'b0});
         end
         if (m_busy) begin
            n_chk++;
            if ({bus.mst_id, bus.mst_addr, bus.mst_len, bus.ord_id, bus.ord_len}
                !== {m_id, m_addr, m_len, m_id, m_len}) begin
               n_fail++;
               $display("FAIL rand_data@%0d: got id=%0d addr=%h len=%0d oid=%0d olen=%0d want %0d %h %0d",
                        cyc, bus.mst_id, bus.mst_addr, bus.mst_len, bus.ord_id, bus.ord_len,
                        m_id, m_addr, m_len);
            end
         end
         was_busy = m_busy;
         fwd_hsk = bus.fwd_vld && bus.fwd_rdy;
         if (fwd_hsk && q.size() > 0) begin
            if (m_beat == q[0].len) begin
               m_cnt[q[0].id]--;
               void'(q.pop_front());
               m_beat = 0;
            end else begin
               m_beat++;
            end
         end
         if (was_busy) begin
            if (bus.mst_rdy) m_mp = 0;
            if (bus.ord_rdy) m_op = 0;
            if (!m_mp && !m_op) m_busy = 0;
         end else if (bus.req_vld && exp_rdy) begin
            m_cnt[exp_sel]++;
            q.push_back('{exp_sel, int'(bus.req_len)});
            m_rr = (exp_sel + 1) % ND;
            m_busy = 1; m_mp = 1; m_op = 1;
            m_id = IW'(exp_sel); m_addr = bus.req_addr; m_len = bus.req_len;
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_round_robin();
      test_per_id_limit();
      test_split_handshake();
      test_multibeat_retire();
      test_error_and_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
      $fatal(1, "watchdog");
   end
endmodule
